seven_seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a DIGITS-wide common-anode 7-seg display.

---
 rtl/seven_seg_scan_ctrl.sv | 103 ++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One external nibble decoder is shared across all digits; the displayed value is double-buffered.
module seven_seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  output logic [3:0]            dec_nibble,
  input  logic [6:0]            dec_seg,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_start,
  output logic                  upd_pending
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] disp;
  logic [4*DIGITS-1:0] pend;
  logic                pflag;

  logic [DIGITS-1:0]   idx_hot;
  logic                sel_blank;
  logic                sel_lz;
  logic                zacc;
  logic                off;
  logic                slot_end;
  logic                frame_wrap;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);

  // Walk from the leftmost digit down so zacc holds "this and every higher nibble is zero".
  always_comb begin
    dec_nibble = 4'h0;
    idx_hot    = '0;
    sel_blank  = 1'b0;
    sel_lz     = 1'b0;
    zacc       = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zacc = zacc & (disp[4*k +: 4] == 4'h0);
      if (idx == IW'(k)) begin
        dec_nibble = disp[4*k +: 4];
        idx_hot[k] = 1'b1;
        sel_blank  = blank[k];
        sel_lz     = (k != 0) && zacc;
      end
    end
  end

  assign off = sel_blank || (cnt < CNT_BLANK) || (lz_en && sel_lz);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      disp        <= '0;
      pend        <= '0;
      pflag       <= 1'b0;
      seg_n       <= 7'h7F;
      an_n        <= '1;
      frame_start <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      frame_start <= frame_wrap;

      // The display only ever changes on the frame wrap, so a frame never mixes two values.
      if (frame_wrap && pflag)
        disp <= pend;

      if (load) begin
        pend  <= value;
        pflag <= 1'b1;
      end else if (frame_wrap) begin
        pflag <= 1'b0;
      end

      seg_n <= off ? 7'h7F : dec_seg;
      an_n  <= off ? '1 : ~idx_hot;
    end
  end

  assign upd_pending = pflag;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a stub nibble-to-7-segment decoder.
// Small scan parameters keep each frame at 32 cycles.
module tb_seven_seg_scan_ctrl;

  logic        clock;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank;
  logic        lz_en;
  logic [3:0]  dec_nibble;
  logic [6:0]  dec_seg;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_start;
  logic        upd_pending;

  int checks;
  int errors;
  int n;
  logic prev_pend;
  logic mon_en;

  seven_seg_scan_ctrl #(
    .DIGITS(4),
    .TICK_DIV(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .value(value),
    .load(load),
    .blank(blank),
    .lz_en(lz_en),
    .dec_nibble(dec_nibble),
    .dec_seg(dec_seg),
    .seg_n(seg_n),
    .an_n(an_n),
    .frame_start(frame_start),
    .upd_pending(upd_pending)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    case (nib)
      4'h0: seg_of = 7'b1000000;
      4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;
      4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;
      4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;
      4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0010000;
      4'hA: seg_of = 7'b0001000;
      4'hB: seg_of = 7'b0000011;
      4'hC: seg_of = 7'b1000110;
      4'hD: seg_of = 7'b0100001;
      4'hE: seg_of = 7'b0000110;
      default: seg_of = 7'b0001110;
    endcase
  endfunction

  always_comb dec_seg = seg_of(dec_nibble);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Dark cycles must have both anodes and segments fully off; 7F is never a decoder output.
  always @(negedge clock) begin
    if (mon_en) begin
      check_val("an_onehot", ($countones(~an_n) <= 1), 1);
      check_val("seg_dark_an_off", (seg_n == 7'h7F) ? (an_n == 4'hF) : 1'b1, 1);
    end
  end

  // Entered just after a frame-wrap edge; runs one 32-cycle frame and checks every output cycle.
  task automatic check_frame(input string tag, input logic [15:0] exp_val, input logic [3:0] exp_lit,
                             input int la1, input logic [15:0] lv1,
                             input int la2, input logic [15:0] lv2);
    int lit [4];
    int segbad;
    int bad;
    int nibbad;
    int fsbad;
    int slot;
    int c;
    logic [3:0] one;
    logic [3:0] hot_n;
    segbad = 0; bad = 0; nibbad = 0; fsbad = 0;
    one = 4'b0001;
    for (int k = 0; k < 4; k++) lit[k] = 0;
    for (int j = 1; j <= 32; j++) begin
      @(posedge clock); #1;
      load = 1'b0;
      slot = (j - 1) / 8;
      c = (j - 1) % 8;
      hot_n = ~(one << slot);
      if (an_n == 4'hF && seg_n == 7'h7F) begin
      end else if (an_n == hot_n) begin
        if (c < 2) bad++;
        else lit[slot]++;
        if (seg_n != seg_of(exp_val[4*slot +: 4])) segbad++;
      end else begin
        bad++;
      end
      if (frame_start != (j == 32)) fsbad++;
      if (j < 32 && dec_nibble != exp_val[4*(j/8) +: 4]) nibbad++;
      if (j == la1) begin value = lv1; load = 1'b1; end
      if (j == la2) begin value = lv2; load = 1'b1; end
    end
    for (int k = 0; k < 4; k++)
      check_val($sformatf("%s_lit%0d", tag, k), lit[k], exp_lit[k] ? 6 : 0);
    check_val({tag, "_seg"}, segbad, 0);
    check_val({tag, "_anode"}, bad, 0);
    check_val({tag, "_frame_start"}, fsbad, 0);
    check_val({tag, "_nibble"}, nibbad, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    value = 16'h0;
    load  = 1'b0;
    blank = 4'b0;
    lz_en = 1'b0;

    // T1: reset mid-scan, then measure time to first frame_start
    repeat (2) @(posedge clock);
    #1;
    mon_en = 1'b1;
    reset = 1'b0;
    repeat (13) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_val("t1_seg_n", seg_n, 7'h7F);
    check_val("t1_an_n", an_n, 4'hF);
    check_val("t1_frame_start", frame_start, 0);
    check_val("t1_upd_pending", upd_pending, 0);
    reset = 1'b0;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!frame_start && n < 64);
    check_val("t1_first_frame", n, 32);

    // T2: load lands on the next frame boundary
    value = 16'h1234;
    load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
    check_val("t2_pend_set", upd_pending, 1);
    n = 0;
    prev_pend = 1'b0;
    while (!frame_start && n < 40) begin
      prev_pend = upd_pending;
      @(posedge clock); #1;
      n++;
    end
    check_val("t2_load_to_frame", n, 31);
    check_val("t2_pend_held", prev_pend, 1);
    check_val("t2_pend_clr", upd_pending, 0);
    check_frame("t2a", 16'h1234, 4'b1111, 0, 16'h0, 0, 16'h0);
    check_val("t2_pend_idle", upd_pending, 0);

    // T3: mid-frame load must not tear the current frame
    check_frame("t3a", 16'h1234, 4'b1111, 12, 16'hABCD, 0, 16'h0);
    check_val("t3_pend_clr", upd_pending, 0);

    // T4: second load exactly on the wrap cycle with pflag already set
    check_frame("t3b", 16'hABCD, 4'b1111, 5, 16'h5678, 31, 16'h9E0F);
    check_val("t4_pend_kept", upd_pending, 1);
    check_frame("t4a", 16'h5678, 4'b1111, 0, 16'h0, 0, 16'h0);
    check_val("t4_pend_clr", upd_pending, 0);

    // T5: leading-zero suppression
    lz_en = 1'b1;
    check_frame("t4b", 16'h9E0F, 4'b1111, 3, 16'h0050, 0, 16'h0);
    check_frame("t5a", 16'h0050, 4'b0011, 3, 16'h0000, 0, 16'h0);
    check_frame("t5b", 16'h0000, 4'b0001, 3, 16'h1234, 0, 16'h0);

    // T6: per-digit blank mask
    lz_en = 1'b0;
    blank = 4'b0100;
    check_frame("t6", 16'h1234, 4'b1011, 0, 16'h0, 0, 16'h0);
    blank = 4'b0000;

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
